// File: rtl/bht_port_ctrl.sv
// -----------------------------------------------------------------------------
// bht_port_ctrl
//
// Sequencer for a single-ported pattern history table (PHT) of 2^IDX_W
// two-bit saturating branch counters kept in an external SRAM with a 1-cycle
// read latency. Fetch-side lookups and execute-side resolved-branch updates
// share the one SRAM port. The table is cleared to INIT_VAL after reset.
// Updates are queued in a small FIFO and applied as read-modify-writes.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   lookup_valid/idx/ready      fetch prediction request handshake
//   pred_valid, pred_taken      prediction, one cycle after an accepted lookup
//   upd_valid/idx/taken/ready   resolved-branch update handshake (into FIFO)
//   mem_en/we/addr/wdata        SRAM command port
//   mem_rdata                   SRAM read data, valid the cycle after a read
//   init_done                   table initialisation complete
//
// state   | meaning
// --------+---------------------------------------------------------------
// INIT    | write INIT_VAL to every entry, one address per cycle
// RUN     | arbitrate the port: full-FIFO drain > lookup > pending update
// UPD_WR  | write back the saturated counter for the FIFO head, then pop
// -----------------------------------------------------------------------------
module bht_port_ctrl #(
    parameter int         IDX_W      = 6,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VAL   = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [1:0]       mem_wdata,
    input  logic [1:0]       mem_rdata,
    output logic             init_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPD_WR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
    logic               init_done_q, init_done_d;
    logic               pred_valid_q, pred_valid_d;

    // FIFO entry layout: {idx, taken}
    logic [IDX_W:0]     fifo_q [FIFO_DEPTH];
    logic [IDX_W:0]     fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [IDX_W-1:0]   head_idx;
    logic               head_taken;
    logic [1:0]         ctr_new;

    logic               mem_en_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   mem_addr_c;
    logic [1:0]         mem_wdata_c;

    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        {head_idx, head_taken} = fifo_q[rd_ptr_q];
    end

    assign upd_ready    = init_done_q && !fifo_full;
    assign lookup_ready = (state_q == ST_RUN) && !fifo_full;
    assign push         = upd_valid && upd_ready;
    assign init_done    = init_done_q;
    assign pred_valid   = pred_valid_q;
    // Read data is only meaningful in the cycle after an accepted lookup.
    assign pred_taken   = pred_valid_q & mem_rdata[1];

    // Saturating counter update for the head entry, from the read issued in RUN.
    always_comb begin
        ctr_new = mem_rdata;
        if (head_taken) begin
            if (mem_rdata != 2'b11) ctr_new = mem_rdata + 2'd1;
        end else begin
            if (mem_rdata != 2'b00) ctr_new = mem_rdata - 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        pred_valid_d = 1'b0;
        pop          = 1'b0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;

        case (state_q)
            ST_INIT: begin
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = init_cnt_q;
                mem_wdata_c = INIT_VAL;
                init_cnt_d  = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A full FIFO takes the port ahead of lookups so updates
                // cannot be starved by a continuous lookup stream.
                if (fifo_full) begin
                    mem_en_c   = 1'b1;
                    mem_addr_c = head_idx;
                    state_d    = ST_UPD_WR;
                end else if (lookup_valid) begin
                    mem_en_c     = 1'b1;
                    mem_addr_c   = lookup_idx;
                    pred_valid_d = 1'b1;
                end else if (!fifo_empty) begin
                    mem_en_c   = 1'b1;
                    mem_addr_c = head_idx;
                    state_d    = ST_UPD_WR;
                end
            end
            ST_UPD_WR: begin
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = head_idx;
                mem_wdata_c = ctr_new;
                pop         = 1'b1;
                state_d     = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // The state register already sits in INIT during reset; keep the
        // SRAM port quiet until reset is actually released.
        if (!rst_n) begin
            mem_en_c    = 1'b0;
            mem_we_c    = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end
    end

    assign mem_en    = mem_en_c;
    assign mem_we    = mem_we_c;
    assign mem_addr  = mem_addr_c;
    assign mem_wdata = mem_wdata_c;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {upd_idx, upd_taken};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            pred_valid_q <= pred_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_q       <= fifo_d;
        end
    end

endmodule
